// File: rtl/aes_pkg.sv
// Shared constants, key-length decode and GF(2^8) helpers for the AES key schedule.
package aes_pkg;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  localparam logic [5:0] TW_128 = 6'd44;
  localparam logic [5:0] TW_192 = 6'd52;
  localparam logic [5:0] TW_256 = 6'd60;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
    logic [5:0] total;
  } key_cfg_t;

  // Reserved encoding 2'b11 falls into the 128-bit default.
  function automatic key_cfg_t decode_key_len(input logic [1:0] kl);
    case (kl)
      KL_192:  return '{nk: NK_192, nr: NR_192, total: TW_192};
      KL_256:  return '{nk: NK_256, nr: NR_256, total: TW_256};
      default: return '{nk: NK_128, nr: NR_128, total: TW_128};
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational next schedule word: w_next = w_nk ^ f(w_prev), f chosen by rot_en/sub_en.
module aes_key_word_gen
  import aes_pkg::*;
(
  input  logic [31:0] w_prev,
  input  logic [31:0] w_nk,
  input  logic        rot_en,
  input  logic        sub_en,
  input  logic [7:0]  rcon,
  output logic [31:0] w_next
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_temp;

  // Byte 0 lives at [7:0], so RotWord moves byte 0 to the top.
  assign w_rot = rot_en ? {w_prev[7:0], w_prev[31:8]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*b +: 8]),
      .o_byte (w_sub[8*b +: 8])
    );
  end

  assign w_temp = (rot_en || sub_en) ? w_sub : w_prev;
  assign w_next = w_nk ^ w_temp ^ (rot_en ? {24'h0, rcon} : 32'h0);

endmodule

// File: rtl/aes_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) (as x^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] sbox_fn(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign o_byte = sbox_fn(i_byte);

endmodule

// File: rtl/mul_by_2.sv
// Multiply a GF(2^8) element by x; advances the round constant.
module mul_by_2
  import aes_pkg::*;
(
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);

  assign o_y = xtime(i_a);

endmodule

// File: rtl/aes_key_expander.sv
// Expands a 128/192/256-bit key one word per cycle and serves round keys with per-round valid.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  input  logic [3:0]   Addr,
  output logic [128:0] Key,
  output logic [3:0]   Nr,
  output logic         key_busy
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_w [0:59];
  logic [5:0]  r_cnt;
  logic [5:0]  r_total;
  logic [3:0]  r_nk;
  logic [3:0]  r_nr;
  logic [2:0]  r_pos;
  logic [7:0]  r_rcon;

  key_cfg_t    w_cfg;
  logic [5:0]  w_prev_idx;
  logic [5:0]  w_nk_idx;
  logic        w_rot_en;
  logic        w_sub_en;
  logic        w_last;
  logic [31:0] w_next;
  logic [7:0]  w_rcon_next;
  logic [3:0]  w_rd_round;
  logic [5:0]  w_base;

  assign w_cfg      = decode_key_len(key_len);
  assign w_prev_idx = r_cnt - 6'd1;
  assign w_nk_idx   = r_cnt - {2'b00, r_nk};
  // r_pos tracks i mod Nk without a divider.
  assign w_rot_en   = (r_pos == 3'd0);
  assign w_sub_en   = (r_nk == NK_256) && (r_pos == 3'd4);
  assign w_last     = (r_cnt + 6'd1 == r_total);

  aes_key_word_gen u_word_gen (
    .w_prev (r_w[w_prev_idx]),
    .w_nk   (r_w[w_nk_idx]),
    .rot_en (w_rot_en),
    .sub_en (w_sub_en),
    .rcon   (r_rcon),
    .w_next (w_next)
  );

  mul_by_2 u_rcon_step (
    .i_a (r_rcon),
    .o_y (w_rcon_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: default assignment first so no path through the block leaves a latch.
  always_comb begin
    w_state_next = r_state;
    if (key_load)                             w_state_next = S_EXPAND;
    else if (r_state == S_EXPAND && w_last)   w_state_next = S_IDLE;
  end

  always_comb begin
    key_busy = (r_state == S_EXPAND);
  end

  // NOTE: the word array is reset because a zero Key after reset is an observable requirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 60; j++) r_w[j] <= 32'h0;
      r_cnt   <= 6'd0;
      r_pos   <= 3'd0;
      r_rcon  <= RCON_INIT;
      r_nk    <= NK_128;
      r_nr    <= NR_128;
      r_total <= TW_128;
    end else if (key_load) begin
      for (int j = 0; j < 8; j++) begin
        if (4'(j) < w_cfg.nk) r_w[j] <= key_in[32*j +: 32];
      end
      r_nk    <= w_cfg.nk;
      r_nr    <= w_cfg.nr;
      r_total <= w_cfg.total;
      r_cnt   <= {2'b00, w_cfg.nk};
      r_pos   <= 3'd0;
      r_rcon  <= RCON_INIT;
    end else if (key_busy) begin
      r_w[r_cnt] <= w_next;
      r_cnt      <= r_cnt + 6'd1;
      r_pos      <= ({1'b0, r_pos} == r_nk - 4'd1) ? 3'd0 : r_pos + 3'd1;
      if (w_rot_en) r_rcon <= w_rcon_next;
    end
  end

  // Out-of-range addresses read the last round's slice so the bus stays stable.
  assign w_rd_round = (Addr > r_nr) ? r_nr : Addr;
  assign w_base     = {w_rd_round, 2'b00};
  assign Nr         = r_nr;

  assign Key[127:0] = {r_w[w_base + 6'd3], r_w[w_base + 6'd2], r_w[w_base + 6'd1], r_w[w_base]};
  assign Key[128]   = ({1'b0, r_cnt} >= ({1'b0, Addr, 2'b00} + 7'd4)) && (Addr <= r_nr);

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed FIPS-197 vectors for the key expander: timing, valid windows, reload and reset.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   Addr;
  logic [128:0] Key;
  logic [3:0]   Nr;
  logic         key_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_expander dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key_len  (key_len),
    .key_in   (key_in),
    .Addr     (Addr),
    .Key      (Key),
    .Nr       (Nr),
    .key_busy (key_busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Literals are written byte 0 first (leftmost); the bus wants byte 0 at [7:0].
  function automatic logic [255:0] brev(input logic [255:0] x, input int n);
    logic [255:0] y;
    y = '0;
    for (int i = 0; i < n; i++) y[8*i +: 8] = x[8*(n-1-i) +: 8];
    return y;
  endfunction

  function automatic logic [128:0] rk(input logic [127:0] x);
    logic [255:0] t;
    t = brev({128'h0, x}, 16);
    return {1'b1, t[127:0]};
  endfunction

  task automatic load(input logic [1:0] len, input logic [255:0] lit, input int nbytes);
    @(negedge clk);
    key_len  = len;
    key_in   = brev(lit, nbytes);
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (key_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [128:0] k);
    Addr = a;
    #1;
    k = Key;
  endtask

  initial begin
    logic [128:0] kk;
    int n;
    int first_rise;
    int early10;
    int bad_hi;

    rst_n = 1'b0; key_load = 1'b0; key_len = 2'b00; key_in = '0; Addr = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(4'd0, kk);
    check("reset_key", kk, 129'h0);
    check("reset_nr", {125'h0, Nr}, 129'd10);
    check("reset_busy", {128'h0, key_busy}, 129'd0);

    // 128-bit vector
    load(KL_128_C(), K128, 16);
    busy_len(n);
    check("b128_busy_len", 129'(n), 129'd40);
    check("b128_nr", {125'h0, Nr}, 129'd10);
    rd(4'd10, kk); check("b128_rk10", kk, rk(R128_10));
    rd(4'd1, kk);  check("b128_rk1", kk, rk(R128_1));
    rd(4'd0, kk);  check("b128_rk0", kk, rk(R128_0));

    // 192-bit vector
    load(2'b01, K192, 24);
    busy_len(n);
    check("b192_busy_len", 129'(n), 129'd46);
    check("b192_nr", {125'h0, Nr}, 129'd12);
    rd(4'd12, kk); check("b192_rk12", kk, rk(R192_12));
    rd(4'd13, kk); check("b192_rk13_invalid", {128'h0, kk[128]}, 129'd0);

    // 256-bit vector
    load(2'b10, K256, 32);
    busy_len(n);
    check("b256_busy_len", 129'(n), 129'd52);
    check("b256_nr", {125'h0, Nr}, 129'd14);
    rd(4'd14, kk); check("b256_rk14", kk, rk(R256_14));

    // Overlap: per-round valid while expansion runs
    load(2'b00, K128, 16);
    first_rise = -1; early10 = 0; bad_hi = 0;
    for (int k = 0; k < 60 && key_busy; k++) begin
      rd(4'd1, kk);
      if (kk[128] && first_rise < 0) first_rise = k;
      rd(4'd10, kk);
      if (kk[128]) early10++;
      for (int a = 11; a < 16; a++) begin
        rd(4'(a), kk);
        if (kk[128]) bad_hi++;
      end
      @(negedge clk);
    end
    for (int a = 11; a < 16; a++) begin
      rd(4'(a), kk);
      if (kk[128]) bad_hi++;
    end
    check("ovl_rk1_rise_cycle", 129'(first_rise), 129'd4);
    check("ovl_rk10_early_valid", 129'(early10), 129'd0);
    check("ovl_hi_addr_valid", 129'(bad_hi), 129'd0);
    rd(4'd10, kk); check("ovl_rk10_final", kk, rk(R128_10));

    // Reload mid-expansion: 256-bit then 128-bit
    load(2'b10, K256, 32);
    repeat (20) @(negedge clk);
    rd(4'd2, kk); check("rl_rk2_before", {128'h0, kk[128]}, 129'd1);
    load(2'b00, K128, 16);
    rd(4'd2, kk); check("rl_rk2_after", {128'h0, kk[128]}, 129'd0);
    check("rl_nr", {125'h0, Nr}, 129'd10);
    rd(4'd0, kk); check("rl_rk0", kk, rk(R128_0));
    busy_len(n);
    check("rl_busy_len", 129'(n), 129'd40);
    rd(4'd10, kk); check("rl_rk10", kk, rk(R128_10));

    // Asynchronous reset mid-expansion
    load(2'b01, K192, 24);
    repeat (10) @(negedge clk);
    Addr = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_key", Key, 129'h0);
    check("rst_busy", {128'h0, key_busy}, 129'd0);
    check("rst_nr", {125'h0, Nr}, 129'd10);
    @(negedge clk);
    rst_n = 1'b1;
    load(2'b00, K128, 16);
    busy_len(n);
    check("rst_reload_busy_len", 129'(n), 129'd40);
    rd(4'd10, kk); check("rst_reload_rk10", kk, rk(R128_10));

    // Reserved key_len behaves as 128-bit
    load(2'b11, K128, 16);
    check("rsv_nr", {125'h0, Nr}, 129'd10);
    busy_len(n);
    check("rsv_busy_len", 129'(n), 129'd40);
    rd(4'd10, kk); check("rsv_rk10", kk, rk(R128_10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  function automatic logic [1:0] KL_128_C();
    return 2'b00;
  endfunction

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Upstream partner of the AES round datapath: expands a 128/192/256-bit cipher key into the full FIPS-197 round-key schedule.
- Serves round keys on the {valid, key} bus indexed by the datapath's 4-bit round address.
- Computes one 32-bit schedule word per cycle into an internal register array.
- Per-round valid lets encryption start as soon as early round keys exist.

Parameters:
None; all widths and counts are fixed by FIPS-197.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
key_load  input  1  pulse; samples key_in/key_len and (re)starts expansion
key_len  input  2  00=128-bit, 01=192-bit, 10=256-bit, 11=reserved (treated as 128-bit)
key_in  input  256  cipher key; byte 0 at [7:0], ascending; 128-bit uses [127:0], 192-bit uses [191:0]
Addr  input  4  round index requested by datapath
Key  output  129  [128]=round key valid, [127:0]=round key Addr
Nr  output  4  round count of loaded key: 10/12/14
key_busy  output  1  high while expansion in progress

Behaviour:
- Byte order:
  - Word w[j] byte 0 sits at bits [7:0].
  - Round key r = {w[4r+3],w[4r+2],w[4r+1],w[4r]}, so w[4r] drives Key[31:0].
- Key length parameters:
  - Nk = 4/6/8 and Nr = 10/12/14.
  - Total words T = 44/52/60.
- Reset state:
  - Word array all 0; cnt=0; Nr=4'hA; key_busy=0; Key=129'h0.
  - rcon=8'h01; position counter = 0.
- Load edge (key_load=1 sampled):
  - Latch Nk/Nr.
  - Write w[0..Nk-1] from key_in.
  - cnt=Nk; rcon=01; key_busy=1.
- Expansion, one word per subsequent edge while key_busy:
  - i = cnt, temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {24'h0, rcon}, then rcon = xtime(rcon).
  - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; cnt++.
- RotWord in this byte order is {w[7:0], w[31:8]}. Rcon XORs into byte 0 ([7:0]).
- Track i mod Nk with a wrap counter; no divider.
- Completion:
  - When cnt reaches T at an edge, key_busy=0 from that edge onward.
  - Busy duration after the load edge is exactly 40/46/52 cycles for 128/192/256.
- Read side is combinational, so Key follows Addr in the same cycle:
  - Key[127:0] = round key Addr.
  - Key[128] = (cnt >= 4*Addr+4) && (Addr <= Nr).
  - For Addr > Nr: Key[128]=0 and Key[127:0] is don't-care but held stable (return w-array slice clamped to Nr).
- Overlap:
  - Round 0 is valid the cycle after the load edge.
  - Round r becomes valid exactly when its 4th word is written.
  - A decryption start at Addr=Nr stalls naturally until expansion completes.
- key_load while key_busy: abort the current expansion and restart from the new key. All rounds ≥ Nk/4 go invalid immediately.
- key_load while idle: same restart. It is the system controller's job not to reload while the datapath is mid-block; the block gives no protection.
- key_load held high: re-samples every cycle, so expansion never progresses past cnt=Nk. This is legal.
- Reserved key_len=11 behaves exactly as 00.
- Asynchronous reset mid-expansion returns all state to reset values; Key[128]=0 immediately.

Decomposition:
- Package aes_pkg holds:
  - key_len encodings KL_128/KL_192/KL_256.
  - Per-length NK and NR constants and total word counts 44/52/60.
  - RCON_INIT=8'h01.
- Sub-module aes_key_word_gen: combinational next-word function.
  - Inputs: w_prev, w_nk, rot_en, sub_en, rcon. Output: w_next.
  - Built from 4 existing aes_sbox instances.
- Rcon update reuses existing mul_by_2.
- The top holds the FSM (IDLE/EXPAND), counters, the 60x32 array and the read mux.

Test Plan:
- 128-bit:
  - Stimulus: load key 2b7e1516 28aed2a6 abf71588 09cf4f3c (key_in[7:0]=2b); wait 40 cycles.
  - Response: key_busy=1 for exactly 40 cycles; Nr=10.
  - Addr=10 gives valid=1 and bytes d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6 from Key[7:0] upward.
- 192-bit:
  - Stimulus: load 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - Response: busy 46 cycles; Nr=12.
  - Addr=12 gives bytes e9 8b a0 6f 44 8c 77 3c 8e cc 72 04 01 00 22 02.
- 256-bit:
  - Stimulus: load 603deb10 ... 0914dff4.
  - Response: busy 52 cycles; Nr=14.
  - Addr=14 gives bytes fe 48 90 d1 e6 18 8d 0b 04 6d f3 44 70 6c 63 1e.
- Overlap: 128-bit load, Addr=1 held.
  - Key[128] rises exactly 4 cycles after the load edge (cnt=8).
  - Addr=10 stays invalid until busy falls.
  - Addr=11..15 is never valid.
- Reload mid-expansion: 256-bit load, then a 128-bit key_load 20 cycles later.
  - Addr=2 drops invalid at the second edge; Nr=10 immediately.
  - Final round keys match the 128-bit vector; busy lasts 40 cycles from the second load.
- Reset mid-expansion: assert rst_n=0 during busy.
  - Key=0, key_busy=0, Nr=10 asynchronously.
  - A subsequent load expands correctly.
